pipeline_hazard_ctrl: RTL

Stall/flush controller for the 5-stage RISC-V pipeline: drives the enable and flush inputs of the IF/ID register and the PC, and the enable and bubble controls of the ID/EX and EX/MEM registers. It detects load-use hazards, branch/jump redirects, and data-memory wait states. It also remembers a redirect that arrives during a memory freeze and replays it once the freeze ends. It sits in the core top beside the pipeline registers and consumes decode and execute sideband signals.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 41 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: register index width, x0 index and the
// per-mode control vectors for the hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_FREEZE,
    MODE_REDIRECT,
    MODE_LOAD_USE,
    MODE_RUN
  } ctrl_mode_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_bubble;
    logic ex_mem_en;
  } ctrl_t;

  function automatic ctrl_t mode_ctrl(input ctrl_mode_e mode);
    ctrl_t c;
    c = '0;
    case (mode)
      MODE_REDIRECT: c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                           id_ex_en: 1'b1, id_ex_bubble: 1'b1, ex_mem_en: 1'b1};
      // Hold PC and IF/ID, push a bubble behind the load as it moves to MEM.
      MODE_LOAD_USE: c = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                           id_ex_en: 1'b1, id_ex_bubble: 1'b1, ex_mem_en: 1'b1};
      MODE_RUN:      c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                           id_ex_en: 1'b1, id_ex_bubble: 1'b0, ex_mem_en: 1'b1};
      default:       c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the load in EX writes a register the ID
// instruction reads. x0 is never a hazard.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard  = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with freeze watchdog and
// redirect replay. Performance counters exist only with HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int FREEZE_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             freeze_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam logic [7:0] FREEZE_MAX_L = 8'(FREEZE_MAX);

  logic       hazard;
  ctrl_mode_e mode;
  ctrl_t      ctrl;

  logic       pending_redirect_q, pending_redirect_d;
  logic [7:0] freeze_len_q, freeze_len_d;
  logic       freeze_timeout_q, freeze_timeout_d;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  always_comb begin
    mode = MODE_RUN;
    if (reset)                                 mode = MODE_RESET;
    else if (mem_busy)                         mode = MODE_FREEZE;
    else if (ex_redirect || pending_redirect_q) mode = MODE_REDIRECT;
    else if (hazard)                           mode = MODE_LOAD_USE;
  end

  assign ctrl         = mode_ctrl(mode);
  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_en     = ctrl.id_ex_en;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_mem_en    = ctrl.ex_mem_en;

  always_comb begin
    pending_redirect_d = pending_redirect_q;
    freeze_len_d       = 8'd0;
    freeze_timeout_d   = freeze_timeout_q;
    if (mode == MODE_FREEZE) begin
      // A redirect seen while frozen is replayed once the memory releases.
      if (ex_redirect) pending_redirect_d = 1'b1;
      freeze_len_d = (freeze_len_q == 8'hFF) ? freeze_len_q : freeze_len_q + 8'd1;
      if (freeze_len_d >= FREEZE_MAX_L) freeze_timeout_d = 1'b1;
    end else if (mode == MODE_REDIRECT) begin
      pending_redirect_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_redirect_q <= 1'b0;
      freeze_len_q       <= 8'd0;
      freeze_timeout_q   <= 1'b0;
    end else begin
      pending_redirect_q <= pending_redirect_d;
      freeze_len_q       <= freeze_len_d;
      freeze_timeout_q   <= freeze_timeout_d;
    end
  end

  assign freeze_timeout = freeze_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    case (mode)
      MODE_LOAD_USE: stall_cnt_d  = sat_inc(stall_cnt_q);
      MODE_REDIRECT: flush_cnt_d  = sat_inc(flush_cnt_q);
      MODE_FREEZE:   freeze_cnt_d = sat_inc(freeze_cnt_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule
